wb_commit: RTL and testbench

WB_COMMIT -- requirements
Module: wb_commit

---
 rtl/wb_commit.sv | 202 ++++++++++++++++++++
 tb/tb_wb_commit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// wb_commit: write-back / commit stage of a simple in-order pipeline.
// Accepts one instruction per cycle from the MEM stage. Non-loads commit on
// the following cycle. Loads park in WAIT_LOAD until the data memory returns
// the word, which is then byte/halfword selected and extended before commit.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  upstream handshake
//   reg_write, rd, result_src, funct3, alu_result, pc_plus4
//                        instruction fields captured on acceptance
//   dmem_rdata/_rvalid   data-memory read return (only looked at in WAIT_LOAD)
//   we3, a3, wd3         register-file write port (registered, zero when idle)
//   pend_valid, pend_rd  pending-load indication for the hazard unit
//   instret              committed-instruction counter (wraps)
module wb_commit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  input  logic [1:0]  result_src,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    COMMIT    = 2'd2
  } state_t;

  // Select and extend the addressed byte/halfword of an aligned memory word.
  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [1:0]  off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    if (off[1]) begin
      h = w[31:16];
    end else begin
      h = w[15:0];
    end
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  state_t      state_r, state_next_s;
  logic        accept_s, is_load_s, in_we_s;
  logic        commit_s, commit_we_s;
  logic [4:0]  commit_rd_s;
  logic [31:0] commit_data_s;
  logic [4:0]  pend_rd_next_s;

  // Captured load context, held across WAIT_LOAD.
  logic        ld_we_r;
  logic [4:0]  ld_rd_r;
  logic [2:0]  ld_funct3_r;
  logic [1:0]  ld_off_r;

  logic        we3_r, pend_valid_r;
  logic [4:0]  a3_r, pend_rd_r;
  logic [31:0] wd3_r, instret_r;

  assign is_load_s = (result_src == 2'b01);
  assign in_we_s   = reg_write && (rd != 5'd0);
  assign accept_s  = in_valid && in_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; COMMIT accepts exactly like IDLE for back-to-back flow.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE, COMMIT: begin
        if (accept_s) begin
          state_next_s = is_load_s ? WAIT_LOAD : COMMIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_next_s = COMMIT;
        end else begin
          state_next_s = WAIT_LOAD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output logic: handshake plus the values the commit registers load next.
  always_comb begin
    in_ready      = !rst && (state_r != WAIT_LOAD);
    commit_s      = 1'b0;
    commit_we_s   = 1'b0;
    commit_rd_s   = 5'd0;
    commit_data_s = 32'd0;
    case (state_r)
      IDLE, COMMIT: begin
        if (accept_s && !is_load_s) begin
          commit_s      = 1'b1;
          commit_we_s   = in_we_s;
          commit_rd_s   = rd;
          commit_data_s = (result_src == 2'b10) ? pc_plus4 : alu_result;
        end else begin
          commit_s = 1'b0;
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          commit_s      = 1'b1;
          commit_we_s   = ld_we_r;
          commit_rd_s   = ld_rd_r;
          commit_data_s = load_ext(ld_funct3_r, ld_off_r, dmem_rdata);
        end else begin
          commit_s = 1'b0;
        end
      end
      default: commit_s = 1'b0;
    endcase
    // A pending load keeps its rd; a newly accepted load publishes the incoming rd.
    if (state_next_s == WAIT_LOAD) begin
      pend_rd_next_s = (state_r == WAIT_LOAD) ? ld_rd_r : rd;
    end else begin
      pend_rd_next_s = 5'd0;
    end
  end

  // Commit, pending-load and retire-count registers; write fields are zeroed
  // whenever no write happens so the register file sees clean idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3_r        <= 1'b0;
      a3_r         <= 5'd0;
      wd3_r        <= 32'd0;
      pend_valid_r <= 1'b0;
      pend_rd_r    <= 5'd0;
      instret_r    <= 32'd0;
    end else begin
      we3_r        <= commit_we_s;
      a3_r         <= commit_we_s ? commit_rd_s : 5'd0;
      wd3_r        <= commit_we_s ? commit_data_s : 32'd0;
      pend_valid_r <= (state_next_s == WAIT_LOAD);
      pend_rd_r    <= pend_rd_next_s;
      if (commit_s) begin
        instret_r <= instret_r + 32'd1;
      end
    end
  end

  // Load context capture on acceptance of a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_we_r     <= 1'b0;
      ld_rd_r     <= 5'd0;
      ld_funct3_r <= 3'd0;
      ld_off_r    <= 2'd0;
    end else if (accept_s && is_load_s) begin
      ld_we_r     <= in_we_s;
      ld_rd_r     <= rd;
      ld_funct3_r <= funct3;
      ld_off_r    <= alu_result[1:0];
    end
  end

  assign we3        = we3_r;
  assign a3         = a3_r;
  assign wd3        = wd3_r;
  assign pend_valid = pend_valid_r;
  assign pend_rd    = pend_rd_r;
  assign instret    = instret_r;

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: a transaction-level model predicts the
// outputs every cycle, and directed scenarios add hand-computed expectations.
module tb_wb_commit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        reg_write = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [1:0]  result_src = 2'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] pc_plus4 = 32'd0;
  logic [31:0] dmem_rdata = 32'hA5A5_A5A5;
  logic        dmem_rvalid = 1'b0;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic [31:0] instret;

  wb_commit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .reg_write(reg_write), .rd(rd), .result_src(result_src), .funct3(funct3),
    .alu_result(alu_result), .pc_plus4(pc_plus4), .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid), .we3(we3), .a3(a3), .wd3(wd3),
    .pend_valid(pend_valid), .pend_rd(pend_rd), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load extension by shifting and masking.
  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] addr,
                                        input logic [31:0] w);
    logic [31:0] v;
    if (f3[1:0] == 2'b00) begin
      v = (w >> (8 * addr[1:0])) & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'b01) begin
      v = (w >> (16 * addr[1])) & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Transaction-level model: at most one outstanding load; every finished
  // instruction produces one write-back record for the following cycle.
  logic        m_live = 1'b0;
  logic        m_pend = 1'b0;
  logic        m_pwe = 1'b0;
  logic [4:0]  m_prd = 5'd0;
  logic [2:0]  m_pf3 = 3'd0;
  logic [31:0] m_paddr = 32'd0;
  logic        m_we = 1'b0;
  logic [4:0]  m_a3 = 5'd0;
  logic [31:0] m_wd3 = 32'd0;
  logic [31:0] m_instret = 32'd0;

  always @(posedge clk) begin
    logic        c, cwe;
    logic [4:0]  crd;
    logic [31:0] cdat;
    c = 1'b0; cwe = 1'b0; crd = 5'd0; cdat = 32'd0;
    m_live = 1'b1;
    if (rst) begin
      m_pend = 1'b0;
      m_instret = 32'd0;
    end else if (m_pend) begin
      if (dmem_rvalid) begin
        c = 1'b1; cwe = m_pwe; crd = m_prd;
        cdat = m_ext(m_pf3, m_paddr, dmem_rdata);
        m_pend = 1'b0;
      end
    end else if (in_valid) begin
      if (result_src == 2'b01) begin
        m_pend = 1'b1; m_prd = rd; m_pwe = reg_write && (rd != 5'd0);
        m_pf3 = funct3; m_paddr = alu_result;
      end else begin
        c = 1'b1; cwe = reg_write && (rd != 5'd0); crd = rd;
        cdat = (result_src == 2'b10) ? pc_plus4 : alu_result;
      end
    end
    if (c) m_instret = m_instret + 32'd1;
    m_we  = cwe;
    m_a3  = cwe ? crd : 5'd0;
    m_wd3 = cwe ? cdat : 32'd0;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("m_in_ready", 32'(in_ready), 32'(!rst && !m_pend));
      check("m_we3", 32'(we3), 32'(m_we));
      check("m_a3", 32'(a3), 32'(m_a3));
      check("m_wd3", wd3, m_wd3);
      check("m_pend_valid", 32'(pend_valid), 32'(m_pend));
      check("m_pend_rd", 32'(pend_rd), 32'(m_pend ? m_prd : 5'd0));
      check("m_instret", instret, m_instret);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    in_valid = 1'b0; dmem_rvalid = 1'b0; reg_write = 1'b0; rd = 5'd0;
    result_src = 2'd0; funct3 = 3'd0; alu_result = 32'd0; pc_plus4 = 32'd0;
    dmem_rdata = 32'hA5A5_A5A5;
  endtask

  task automatic issue(input logic rw, input logic [4:0] r, input logic [1:0] src,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc);
    in_valid = 1'b1; reg_write = rw; rd = r; result_src = src; funct3 = f3;
    alu_result = alu; pc_plus4 = pc; dmem_rvalid = 1'b0;
  endtask

  task automatic do_load(input logic rw, input logic [4:0] r, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input int waits,
                         input logic [31:0] exp_wd, input string name);
    issue(rw, r, 2'b01, f3, addr, 32'd0);
    tick();
    idle();
    repeat (waits) tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = data;
    tick();
    idle();
    @(negedge clk);
    check({name, "_we3"}, 32'(we3), 32'(rw && (r != 5'd0)));
    check({name, "_wd3"}, wd3, exp_wd);
  endtask

  logic [4:0]  bb_rd  [4] = '{5'd1, 5'd2, 5'd3, 5'd31};
  logic [1:0]  bb_src [4] = '{2'b00, 2'b10, 2'b11, 2'b00};
  logic [31:0] bb_alu [4] = '{32'h1111_1111, 32'h0000_0BAD, 32'h0000_0033, 32'hFFFF_FFFF};
  logic [31:0] bb_pc  [4] = '{32'h0000_0100, 32'h2000_0004, 32'h0000_0200, 32'h0000_0300};
  logic [31:0] bb_exp [4] = '{32'h1111_1111, 32'h2000_0004, 32'h0000_0033, 32'hFFFF_FFFF};

  initial begin
    // Reset behaviour.
    idle();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_instret", instret, 32'd0);
    check("post_rst_we3", 32'(we3), 32'd0);

    // Simple ALU commit.
    issue(1'b1, 5'd5, 2'b00, 3'd0, 32'h0000_1234, 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("alu_we3", 32'(we3), 32'd1);
    check("alu_a3", 32'(a3), 32'd5);
    check("alu_wd3", wd3, 32'h0000_1234);
    check("alu_instret", instret, 32'd1);

    // LB from offset 3 with three idle wait cycles; an offered instruction
    // during the wait must not be taken.
    issue(1'b1, 5'd7, 2'b01, 3'b000, 32'h0000_0103, 32'h0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wait_pend_valid", 32'(pend_valid), 32'd1);
      check("wait_pend_rd", 32'(pend_rd), 32'd7);
      check("wait_in_ready", 32'(in_ready), 32'd0);
      if (i == 1) issue(1'b1, 5'd9, 2'b00, 3'd0, 32'h0000_0999, 32'h0);
      else idle();
      if (i == 3) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80FF_0000;
      end
      tick();
    end
    idle();
    @(negedge clk);
    check("lb_we3", 32'(we3), 32'd1);
    check("lb_a3", 32'(a3), 32'd7);
    check("lb_wd3", wd3, 32'hFFFF_FF80);
    check("lb_instret", instret, 32'd2);

    // Stray dmem_rvalid while idle has no effect.
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    tick();
    idle();
    tick();

    // Extension sweep.
    do_load(1'b1, 5'd10, 3'b100, 32'h0000_0200, 32'h8001_7F80, 0, 32'h0000_0080, "lbu0");
    do_load(1'b1, 5'd11, 3'b001, 32'h0000_0202, 32'h8001_7F80, 1, 32'hFFFF_8001, "lh2");
    do_load(1'b1, 5'd12, 3'b101, 32'h0000_0202, 32'h8001_7F80, 0, 32'h0000_8001, "lhu2");
    do_load(1'b1, 5'd13, 3'b010, 32'h0000_0200, 32'h8001_7F80, 2, 32'h8001_7F80, "lw");
    do_load(1'b1, 5'd14, 3'b000, 32'h0000_0201, 32'h8001_7F80, 0, 32'h0000_007F, "lb1");
    do_load(1'b1, 5'd0, 3'b010, 32'h0000_0300, 32'h1234_5678, 2, 32'h0000_0000, "ld_rd0");
    check("sweep_instret", instret, 32'd8);

    // rd=0 and reg_write=0 still retire without writing.
    issue(1'b1, 5'd0, 2'b00, 3'd0, 32'h0000_DEAD, 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("rd0_we3", 32'(we3), 32'd0);
    check("rd0_a3", 32'(a3), 32'd0);
    check("rd0_wd3", wd3, 32'd0);
    check("rd0_instret", instret, 32'd9);
    issue(1'b0, 5'd9, 2'b00, 3'd0, 32'h0000_DEAD, 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("nowr_we3", 32'(we3), 32'd0);
    check("nowr_wd3", wd3, 32'd0);
    check("nowr_instret", instret, 32'd10);

    // Four back-to-back non-loads.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, bb_rd[i], bb_src[i], 3'd0, bb_alu[i], bb_pc[i]);
      tick();
      @(negedge clk);
      check("b2b_we3", 32'(we3), 32'd1);
      check("b2b_a3", 32'(a3), 32'(bb_rd[i]));
      check("b2b_wd3", wd3, bb_exp[i]);
      check("b2b_in_ready", 32'(in_ready), 32'd1);
    end
    idle();
    tick();
    @(negedge clk);
    check("b2b_end_we3", 32'(we3), 32'd0);
    check("b2b_instret", instret, 32'd14);

    // Reset while a load is outstanding; late data is ignored.
    issue(1'b1, 5'd12, 2'b01, 3'b010, 32'h0000_0400, 32'h0);
    tick();
    idle();
    @(negedge clk);
    check("rl_pend_valid", 32'(pend_valid), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rl_in_ready_rst", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1111_1111;
    tick();
    idle();
    @(negedge clk);
    check("rl_we3", 32'(we3), 32'd0);
    check("rl_instret", instret, 32'd0);
    check("rl_pend_valid_after", 32'(pend_valid), 32'd0);
    check("rl_in_ready", 32'(in_ready), 32'd1);

    // Reset beats an offered instruction in the same cycle.
    tick();
    rst = 1'b1;
    issue(1'b1, 5'd4, 2'b00, 3'd0, 32'h0000_0044, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("rp_we3", 32'(we3), 32'd0);
    check("rp_instret", instret, 32'd0);

    // Link-value commit after recovery.
    issue(1'b1, 5'd6, 2'b10, 3'd0, 32'h0000_0000, 32'h0000_0804);
    tick();
    idle();
    @(negedge clk);
    check("jal_wd3", wd3, 32'h0000_0804);
    check("jal_a3", 32'(a3), 32'd6);
    check("jal_instret", instret, 32'd1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
